// File: rtl/program_loader.sv
// program_loader: streams program bytes into instruction memory port B.
// Byte pairs are packed high byte first into 16-bit words and written from
// word address 0 upward. The CPU is held in reset until the 0x0000
// terminator word (STOP) has been written.
//
// Optional build macro LOADER_CHECKSUM_EN: after the terminator, one extra
// checksum byte is accepted and compared against the XOR of every program
// byte (terminator included). A mismatch ends the load in the error state.
//
// Handshake: a byte transfers only on a rising edge where byte_valid and
// byte_ready are both high. byte_ready depends on state alone, never on
// byte_valid, so the source may hold byte_valid/byte_data until accepted.
module program_loader #(
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              byte_valid,
  input  logic [7:0]        byte_data,
  output logic              byte_ready,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [15:0]       mem_data,
  output logic              mem_w_en,
  output logic              cpu_reset,
  output logic              load_done,
  output logic              load_error,
  output logic [ADDR_W:0]   word_count
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_HI   = 3'd1,
    S_LO   = 3'd2,
    S_WR   = 3'd3,
    S_DONE = 3'd4,
    S_ERR  = 3'd5
`ifdef LOADER_CHECKSUM_EN
    , S_CHK = 3'd6
`endif
  } state_t;

  // state is kept as a named enum so checkers can bind to it directly
  state_t state;
  state_t state_next;

  logic accept;
  logic restart;
  logic last_addr;
  logic word_is_stop;

`ifdef LOADER_CHECKSUM_EN
  logic [7:0] csum;
`endif

  assign accept       = byte_valid && byte_ready;
  assign restart      = start && ((state == S_IDLE) || (state == S_DONE) || (state == S_ERR));
  assign last_addr    = (mem_addr == {ADDR_W{1'b1}});
  assign word_is_stop = (mem_data == 16'h0000);

  // state register
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // next-state logic
  always_comb begin
    state_next = state;
    case (state)
      S_IDLE: begin
        if (start) state_next = S_HI;
      end
      S_HI: begin
        if (accept) state_next = S_LO;
      end
      S_LO: begin
        if (accept) state_next = S_WR;
      end
      S_WR: begin
        if (word_is_stop) begin
`ifdef LOADER_CHECKSUM_EN
          state_next = S_CHK;
`else
          state_next = S_DONE;
`endif
        end else if (last_addr) begin
          // memory full and still no terminator
          state_next = S_ERR;
        end else begin
          state_next = S_HI;
        end
      end
`ifdef LOADER_CHECKSUM_EN
      S_CHK: begin
        if (accept) state_next = (byte_data == csum) ? S_DONE : S_ERR;
      end
`endif
      S_DONE: begin
        if (start) state_next = S_HI;
      end
      S_ERR: begin
        if (start) state_next = S_HI;
      end
      default: state_next = S_IDLE;
    endcase
  end

  // outputs decoded from state only
  always_comb begin
    byte_ready = 1'b0;
    mem_w_en   = 1'b0;
    cpu_reset  = 1'b1;
    load_done  = 1'b0;
    load_error = 1'b0;
    case (state)
      S_HI:   byte_ready = 1'b1;
      S_LO:   byte_ready = 1'b1;
`ifdef LOADER_CHECKSUM_EN
      S_CHK:  byte_ready = 1'b1;
`endif
      S_WR:   mem_w_en   = 1'b1;
      S_DONE: begin
        cpu_reset = 1'b0;
        load_done = 1'b1;
      end
      S_ERR:  load_error = 1'b1;
      default: begin
        byte_ready = 1'b0;
      end
    endcase
  end

  // datapath: byte packing, write address and word counter
  always_ff @(posedge clk) begin
    if (reset) begin
      mem_addr   <= '0;
      mem_data   <= '0;
      word_count <= '0;
    end else begin
      if (restart) begin
        mem_addr   <= '0;
        word_count <= '0;
      end
      if ((state == S_HI) && accept) mem_data[15:8] <= byte_data;
      if ((state == S_LO) && accept) mem_data[7:0]  <= byte_data;
      if (state == S_WR) begin
        word_count <= word_count + 1'b1;
        // the terminator and overflow words leave mem_addr where it was
        if (!word_is_stop && !last_addr) mem_addr <= mem_addr + 1'b1;
      end
    end
  end

`ifdef LOADER_CHECKSUM_EN
  // running XOR over all program bytes, terminator bytes included
  always_ff @(posedge clk) begin
    if (reset) begin
      csum <= 8'h00;
    end else if (restart) begin
      csum <= 8'h00;
    end else if (((state == S_HI) || (state == S_LO)) && accept) begin
      csum <= csum ^ byte_data;
    end
  end
`endif

endmodule
